// File: rtl/timer_pkg.sv
// Shared constants for the MMIO multi-channel timer: register map, channel
// stride, CONFIG field positions and the default base address.
package timer_pkg;

    localparam logic [15:0] DEFAULT_BASE_HI = 16'h3FF5;
    localparam logic [15:0] DEFAULT_BASE_LO = 16'hF000;
    localparam logic [15:0] CH_STRIDE       = 16'h0040;

    localparam logic [5:0] OFF_CONFIG  = 6'h00;
    localparam logic [5:0] OFF_LO      = 6'h04;
    localparam logic [5:0] OFF_HI      = 6'h08;
    localparam logic [5:0] OFF_UPDATE  = 6'h0C;
    localparam logic [5:0] OFF_LOADLO  = 6'h10;
    localparam logic [5:0] OFF_LOADHI  = 6'h14;
    localparam logic [5:0] OFF_LOAD    = 6'h18;
    localparam logic [5:0] OFF_ALARMLO = 6'h1C;
    localparam logic [5:0] OFF_ALARMHI = 6'h20;
    localparam logic [5:0] OFF_STATUS  = 6'h24;

    localparam int CFG_ENABLE_BIT = 31;
    localparam int CFG_UP_BIT     = 30;
    localparam int CFG_RELOAD_BIT = 29;
    localparam int CFG_ALARM_BIT  = 28;
    localparam int CFG_DIV_MSB    = 15;

    typedef enum logic [3:0] {
        REG_CONFIG  = 4'd0,
        REG_LO      = 4'd1,
        REG_HI      = 4'd2,
        REG_UPDATE  = 4'd3,
        REG_LOADLO  = 4'd4,
        REG_LOADHI  = 4'd5,
        REG_LOAD    = 4'd6,
        REG_ALARMLO = 4'd7,
        REG_ALARMHI = 4'd8,
        REG_STATUS  = 4'd9,
        REG_NONE    = 4'd15
    } reg_sel_e;

    function automatic reg_sel_e decode_offset(input logic [5:0] off);
        reg_sel_e sel;
        case (off)
            OFF_CONFIG:  sel = REG_CONFIG;
            OFF_LO:      sel = REG_LO;
            OFF_HI:      sel = REG_HI;
            OFF_UPDATE:  sel = REG_UPDATE;
            OFF_LOADLO:  sel = REG_LOADLO;
            OFF_LOADHI:  sel = REG_LOADHI;
            OFF_LOAD:    sel = REG_LOAD;
            OFF_ALARMLO: sel = REG_ALARMLO;
            OFF_ALARMHI: sel = REG_ALARMHI;
            OFF_STATUS:  sel = REG_STATUS;
            default:     sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: register file, prescaler, up/down counter with
// load, snapshot, alarm compare and auto-reload.
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [3:0]  sel,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    reg_sel_e sel_e;
    assign sel_e = reg_sel_e'(sel);

    logic [31:0]      cfg_q, load_lo_q, load_hi_q, alarm_lo_q, alarm_hi_q;
    logic [CNT_W-1:0] cnt_q, snap_q;
    logic [15:0]      presc_q;
    logic             status_q;

    logic             wr_load, wr_update, wr_status;
    logic             enable, count_up, auto_reload, alarm_en;
    logic [15:0]      div_eff;
    logic             tick, alarm_hit;
    logic [CNT_W-1:0] load_val, alarm_val, step_val, cnt_d;
    logic [15:0]      presc_d;
    logic             status_d;
    logic [63:0]      snap_ext;

    assign wr_load   = wr_en && (sel_e == REG_LOAD);
    assign wr_update = wr_en && (sel_e == REG_UPDATE);
    assign wr_status = wr_en && (sel_e == REG_STATUS);

    assign enable      = cfg_q[CFG_ENABLE_BIT];
    assign count_up    = cfg_q[CFG_UP_BIT];
    assign auto_reload = cfg_q[CFG_RELOAD_BIT];
    assign alarm_en    = cfg_q[CFG_ALARM_BIT];

    // A divider of 0 behaves like 1: one tick per clock.
    assign div_eff = (cfg_q[CFG_DIV_MSB:0] == 16'd0) ? 16'd1 : cfg_q[CFG_DIV_MSB:0];

    assign load_val  = CNT_W'({load_hi_q, load_lo_q});
    assign alarm_val = CNT_W'({alarm_hi_q, alarm_lo_q});
    assign step_val  = count_up ? (cnt_q + CNT_W'(1)) : (cnt_q - CNT_W'(1));

    // A load in the same cycle suppresses the tick entirely.
    assign tick      = enable && !wr_load && (presc_q >= (div_eff - 16'd1));
    assign alarm_hit = tick && alarm_en && (step_val == alarm_val);

    always_comb begin
        cnt_d = cnt_q;
        if (wr_load) begin
            cnt_d = load_val;
        end else if (alarm_hit && auto_reload) begin
            cnt_d = load_val;
        end else if (tick) begin
            cnt_d = step_val;
        end
    end

    always_comb begin
        presc_d = presc_q + 16'd1;
        if (!enable || wr_load || tick) begin
            presc_d = 16'd0;
        end
    end

    always_comb begin
        status_d = status_q;
        if (alarm_hit) begin
            status_d = 1'b1;
        end else if (wr_status && wdata[0]) begin
            status_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_q      <= '0;
            load_lo_q  <= '0;
            load_hi_q  <= '0;
            alarm_lo_q <= '0;
            alarm_hi_q <= '0;
            cnt_q      <= '0;
            snap_q     <= '0;
            presc_q    <= '0;
            status_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            presc_q  <= presc_d;
            status_q <= status_d;
            if (wr_update) begin
                snap_q <= cnt_q;
            end
            if (wr_en) begin
                case (sel_e)
                    REG_CONFIG:  cfg_q      <= wdata;
                    REG_LOADLO:  load_lo_q  <= wdata;
                    REG_LOADHI:  load_hi_q  <= wdata;
                    REG_ALARMLO: alarm_lo_q <= wdata;
                    REG_ALARMHI: alarm_hi_q <= wdata;
                    default:     ;
                endcase
            end
        end
    end

    assign snap_ext = 64'(snap_q);

    always_comb begin
        rdata = 32'd0;
        case (sel_e)
            REG_CONFIG:  rdata = cfg_q;
            REG_LO:      rdata = snap_ext[31:0];
            REG_HI:      rdata = snap_ext[63:32];
            REG_LOADLO:  rdata = load_lo_q;
            REG_LOADHI:  rdata = load_hi_q;
            REG_ALARMLO: rdata = alarm_lo_q;
            REG_ALARMHI: rdata = alarm_hi_q;
            REG_STATUS:  rdata = {31'd0, status_q};
            default:     rdata = 32'd0;
        endcase
    end

    assign irq = status_q && alarm_en;

endmodule

// File: rtl/mmio_multi_timer.sv
// MMIO front end for NUM_CH timer channels: address decode, write steering
// and the one-cycle registered read path.
module mmio_multi_timer
    import timer_pkg::*;
#(
    parameter int          NUM_CH  = 4,
    parameter int          CNT_W   = 64,
    parameter logic [15:0] BASE_HI = DEFAULT_BASE_HI,
    parameter logic [15:0] BASE_LO = DEFAULT_BASE_LO
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       addr_in,
    input  logic [31:0]       data_in,
    input  logic              wr_in,
    input  logic              rd_in,
    output logic              rd_valid_out,
    output logic [31:0]       data_out,
    output logic [NUM_CH-1:0] irq_out
);

    // Bus protocol: wr_in and rd_in are single-cycle strobes with no back-pressure.
    // A write takes effect on the edge that samples it; a read is answered on the
    // following cycle with rd_valid_out=1 and data_out holding the pre-write value.

    logic [16:0] rel_full;
    logic [9:0]  ch_idx;
    logic        addr_hit, mapped;
    reg_sel_e    sel;
    logic [3:0]  sel_bits;

    // Bit 16 of the difference flags addresses below channel 0.
    assign rel_full = {1'b0, addr_in[15:0]} - {1'b0, BASE_LO};
    assign ch_idx   = rel_full[15:6];
    assign addr_hit = (addr_in[31:16] == BASE_HI) && !rel_full[16] && (ch_idx < 10'(NUM_CH));
    assign sel      = decode_offset(rel_full[5:0]);
    assign mapped   = addr_hit && (sel != REG_NONE);
    assign sel_bits = sel;

    logic [31:0] ch_rdata [NUM_CH];
    logic [31:0] rd_mux;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic ch_wr;
        assign ch_wr = wr_in && mapped && (ch_idx == 10'(g));

        timer_channel #(
            .CNT_W(CNT_W)
        ) u_channel (
            .clk  (clk),
            .rst  (rst),
            .wr_en(ch_wr),
            .sel  (sel_bits),
            .wdata(data_in),
            .rdata(ch_rdata[g]),
            .irq  (irq_out[g])
        );
    end

    always_comb begin
        rd_mux = 32'd0;
        if (mapped) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_idx == 10'(i)) begin
                    rd_mux = ch_rdata[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_out <= 1'b0;
            data_out     <= 32'd0;
        end else begin
            rd_valid_out <= rd_in;
            if (rd_in) begin
                data_out <= rd_mux;
            end
        end
    end

endmodule

// File: doc/mmio_multi_timer.md
MMIO_MULTI_TIMER -- requirements
Module: mmio_multi_timer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent timer channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 64, counter width in bits (33..64).
REQ-003 SHALL have parameter BASE_HI, default 16'h3FF5, required value of addr_in[31:16].
REQ-004 SHALL have parameter BASE_LO, default 16'hF000, offset of channel 0; channel n sits at BASE_LO + n*16'h40.
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports addr_in input 32 register address; data_in input 32 write data; wr_in input 1 write strobe; rd_in input 1 read strobe.
REQ-008 SHALL have ports rd_valid_out output 1 read data valid; data_out output 32 read data; irq_out output NUM_CH per-channel level interrupt.

Function
REQ-009 SHALL decode per channel (offset within stride): 0x00 CONFIG, 0x04 LO, 0x08 HI, 0x0C UPDATE, 0x10 LOADLO, 0x14 LOADHI, 0x18 LOAD, 0x1C ALARMLO, 0x20 ALARMHI, 0x24 STATUS.
REQ-010 CONFIG fields SHALL be: bit31 enable, bit30 up (1 increment, 0 decrement), bit29 auto-reload, bit28 alarm enable, bits[15:0] divider; other bits read back as written.
REQ-011 Counter SHALL step by 1 on each tick; tick every max(divider,1) clk cycles while enable=1; prescaler SHALL clear when enable=0 or on load.
REQ-012 Counter arithmetic SHALL be modulo 2^CNT_W (all-ones +1 -> 0; 0 -1 -> all-ones).
REQ-013 Write to LOAD SHALL set counter to {LOADHI,LOADLO} truncated to CNT_W on the next rising edge; load SHALL override a tick in that cycle.
REQ-014 Write to UPDATE SHALL capture the counter value present in the write cycle into LO (bits 31:0) and HI (bits CNT_W-1:32, upper bits zero), visible from the following cycle.
REQ-015 LO, HI, UPDATE, LOAD SHALL be read-only/write-only as implied; writes to LO/HI SHALL be ignored; reads of UPDATE/LOAD SHALL return 0.
REQ-016 When alarm enable=1 and a tick makes counter equal {ALARMHI,ALARMLO}, STATUS[0] SHALL set on that same edge.
REQ-017 On that alarm event with auto-reload=1, counter SHALL take {LOADHI,LOADLO} instead of the alarm value; with auto-reload=0 counting SHALL continue.
REQ-018 STATUS[0] SHALL be write-1-to-clear; a set event in the same cycle as a clear SHALL win.
REQ-019 irq_out[n] SHALL equal STATUS[0] of channel n AND alarm enable of channel n, registered-free from those flops.
REQ-020 Read SHALL have latency 1: rd_valid_out = rd_in delayed one cycle; data_out holds selected register one cycle after rd_in.
REQ-021 Reads with addr_in[31:16] != BASE_HI, unmapped offsets, or channel index >= NUM_CH SHALL return 0 with rd_valid_out still asserted; such writes SHALL have no effect.
REQ-022 Simultaneous wr_in and rd_in to the same register SHALL return the pre-write value.

Reset
REQ-023 On rst low, all registers, counters, prescalers, STATUS SHALL clear to 0 asynchronously; data_out=0, rd_valid_out=0, irq_out=0.
REQ-024 Reset asserted mid-count or mid-read SHALL abort the operation; no pending load or read completes after release.
REQ-025 Block SHALL resume decoding on the first rising edge after rst returns high.

Structure
REQ-026 Package timer_pkg SHALL hold register offset constants, channel stride 16'h40, CONFIG bit positions, and default base address.
REQ-027 Per-channel logic (registers, prescaler, counter, alarm) SHALL be sub-module timer_channel, generated NUM_CH times; top holds address decode and read mux.

Verification
REQ-028 Write CONFIG ch0 = 32'hC000_0000 (enable, up, div 0), wait 10 cycles, UPDATE, read LO -> ~10 (exact per edge count), HI 0.
REQ-029 LOADLO=32'hFFFF_FFFE, LOADHI=32'hFFFF_FFFF, LOAD, enable up div 1, 3 ticks -> counter reads 1 (wrap).
REQ-030 Ch1 divider 4, enable down, LOAD 100, 40 cycles, UPDATE -> LO=90 +/-1 per prescaler phase; ch0 unchanged.
REQ-031 Ch2 ALARM=5, alarm enable + auto-reload, LOAD 0, up -> irq_out[2]=1 on tick reaching 5, counter returns to 0; W1C STATUS -> irq_out[2]=0.
REQ-032 Read offset 0x28 and channel index NUM_CH -> rd_valid_out=1, data_out=0; assert rst mid-count -> all outputs 0 immediately.
